// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data memory responder.
package dmem_pkg;

    // Access size encoding as carried on req_size.
    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_BAD  = 2'b11
    } size_e;

    // Request sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // True when the size is illegal or the address is not naturally aligned.
    function automatic logic size_align_err(input size_e size, input logic [1:0] addr_lo);
        logic err;
        case (size)
            SIZE_BYTE: err = 1'b0;
            SIZE_HALF: err = addr_lo[0];
            SIZE_WORD: err = (addr_lo != 2'b00);
            default:   err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Extracts the addressed byte/halfword/word lane from a memory word and
// zero- or sign-extends it to 32 bits.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  size_e       size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [31:0] shifted;

    // Shift the addressed lane down to bit 0, then extend per size.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        data    = 32'h0;
        shifted = word >> {addr_lo, 3'b000};
        case (size)
            SIZE_BYTE: data = is_unsigned ? {24'h0, shifted[7:0]}
                                          : {{24{shifted[7]}}, shifted[7:0]};
            SIZE_HALF: data = is_unsigned ? {16'h0, shifted[15:0]}
                                          : {{16{shifted[15]}}, shifted[15:0]};
            SIZE_WORD: data = word;
            default:   data = 32'h0;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder over a word-organised data memory
// with a configurable fixed response latency.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_e      state;
    logic [2:0]  count;

    logic        l_we;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;
    size_e       l_size;
    logic        l_unsigned;

    logic [31:0] mem [DEPTH_WORDS];

    // With LATENCY=0 the response is built on the accept edge itself, so the
    // live request fields are used in IDLE and the latched copy afterwards.
    logic        cur_we;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    size_e       cur_size;
    logic        cur_unsigned;
    logic [AW-1:0] idx;
    logic        access_err;
    logic [3:0]  be;
    logic [31:0] wword;
    logic        enter_resp;
    logic [31:0] load_data;

    // Select the transaction fields, decode errors and build store lanes.
    always_comb begin
        cur_we       = (state == ST_IDLE) ? req_we       : l_we;
        cur_addr     = (state == ST_IDLE) ? req_addr     : l_addr;
        cur_wdata    = (state == ST_IDLE) ? req_wdata    : l_wdata;
        cur_size     = (state == ST_IDLE) ? size_e'(req_size) : l_size;
        cur_unsigned = (state == ST_IDLE) ? req_unsigned : l_unsigned;
        idx          = cur_addr[AW+1:2];
        access_err   = size_align_err(cur_size, cur_addr[1:0])
                       || (cur_addr[31:2] >= 30'(DEPTH_WORDS));
        be    = 4'b0000;
        wword = cur_wdata;
        case (cur_size)
            SIZE_BYTE: begin
                be    = 4'b0001 << cur_addr[1:0];
                wword = {4{cur_wdata[7:0]}};
            end
            SIZE_HALF: begin
                be    = cur_addr[1] ? 4'b1100 : 4'b0011;
                wword = {2{cur_wdata[15:0]}};
            end
            SIZE_WORD: be = 4'b1111;
            default:   be = 4'b0000;
        endcase
        enter_resp = !reset && (((state == ST_IDLE) && req_valid && (LATENCY == 0))
                             || ((state == ST_WAIT) && (count == 3'd0)));
    end

    dmem_lane_align u_align (
        .word        (mem[idx]),
        .addr_lo     (cur_addr[1:0]),
        .size        (cur_size),
        .is_unsigned (cur_unsigned),
        .data        (load_data)
    );

    // Commit error-free stores on the edge entering RESP.
    // NOTE: storage has no reset; only control state is cleared, contents persist.
    always_ff @(posedge clk) begin
        if (enter_resp && cur_we && !access_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
            end
        end
    end

    // Request/response sequencer with registered handshake and response outputs.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            count      <= 3'd0;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 32'h0;
            rsp_err    <= 1'b0;
            l_we       <= 1'b0;
            l_addr     <= 32'h0;
            l_wdata    <= 32'h0;
            l_size     <= SIZE_BYTE;
            l_unsigned <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        l_we       <= req_we;
                        l_addr     <= req_addr;
                        l_wdata    <= req_wdata;
                        l_size     <= size_e'(req_size);
                        l_unsigned <= req_unsigned;
                        req_ready  <= 1'b0;
                        if (LATENCY == 0) begin
                            state <= ST_RESP;
                        end else begin
                            state <= ST_WAIT;
                            count <= 3'(LATENCY - 1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (count == 3'd0) state <= ST_RESP;
                    else               count <= count - 3'd1;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= 32'h0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (enter_resp) begin
                rsp_valid <= 1'b1;
                rsp_err   <= access_err;
                rsp_rdata <= (access_err || cur_we) ? 32'h0 : load_data;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: one instance with LATENCY=2, one with LATENCY=0,
// compared against a byte-array reference model.
module tb_data_mem_responder;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset;

    // LATENCY=2 instance signals
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    // LATENCY=0 instance signals
    logic        b_req_valid, b_req_ready, b_req_we, b_req_unsigned;
    logic [31:0] b_req_addr, b_req_wdata;
    logic [1:0]  b_req_size;
    logic        b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [31:0] b_rsp_rdata;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem2 [0:DEPTH*4-1];
    logic [7:0] mem0 [0:DEPTH*4-1];

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_size(b_req_size),
        .req_unsigned(b_req_unsigned),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit ref_err(input logic [31:0] addr, input logic [1:0] size);
        if (size == 2'b11) return 1'b1;
        if (size == 2'b01 && addr[0]) return 1'b1;
        if (size == 2'b10 && addr[1:0] != 2'b00) return 1'b1;
        return (addr / 4) >= DEPTH;
    endfunction

    function automatic logic [31:0] ref_load(input bit inst0, input logic [31:0] addr,
                                             input logic [1:0] size, input bit uns);
        int n;
        logic [31:0] v;
        n = 1 << size;
        v = 32'h0;
        for (int i = 0; i < n; i++)
            v = v | (32'(inst0 ? mem0[int'(addr) + i] : mem2[int'(addr) + i]) << (8 * i));
        if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
        return v;
    endfunction

    task automatic ref_store(input bit inst0, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [1:0] size);
        for (int i = 0; i < (1 << size); i++) begin
            if (inst0) mem0[int'(addr) + i] = wdata[8*i +: 8];
            else       mem2[int'(addr) + i] = wdata[8*i +: 8];
        end
    endtask

    // ---------------- LATENCY=2 transaction driver ----------------
    // Entered and left at a negedge with the DUT idle.
    task automatic txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input bit uns, input int hold,
                       output logic [31:0] rd, output logic er);
        int n;
        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        req_size = size; req_unsigned = uns; rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom;
        req_wdata = $urandom; req_size = 2'($urandom); req_unsigned = 1'($urandom);
        n = 1;
        @(negedge clk);
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, 3);
        rd = rsp_rdata;
        er = rsp_err;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", rsp_valid, 1);
            check("hold_rdata", rsp_rdata, rd);
            check("hold_err", rsp_err, er);
            check("hold_req_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check("post_hs_req_ready", req_ready, 1);
        check("post_hs_rsp_valid", rsp_valid, 0);
    endtask

    task automatic run(input string tag, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] size, input bit uns,
                       input int hold, output logic [31:0] rd, output logic er);
        logic        exp_err;
        logic [31:0] exp_rd;
        exp_err = ref_err(addr, size);
        exp_rd  = (exp_err || we) ? 32'h0 : ref_load(1'b0, addr, size, uns);
        txn(we, addr, wdata, size, uns, hold, rd, er);
        check({tag, "_err"}, er, exp_err);
        check({tag, "_rdata"}, rd, exp_rd);
        if (we && !exp_err) ref_store(1'b0, addr, wdata, size);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, exp_rd;
        logic        er;
        logic [31:0] a;
        logic [1:0]  sz;
        bit          we;

        reset = 1'b1;
        req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_size = 0;
        req_unsigned = 0; rsp_ready = 0;
        b_req_valid = 0; b_req_we = 0; b_req_addr = 0; b_req_wdata = 0;
        b_req_size = 0; b_req_unsigned = 0; b_rsp_ready = 1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", rsp_err, 0);

        // Initialise the words used by the random phase.
        for (int w = 0; w < 16; w++)
            run("init", 1'b1, 32'(w * 4), $urandom, 2'b10, 1'b0, 0, rd, er);

        // Word store then load.
        run("sw10", 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 0, rd, er);
        run("lw10", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, rd, er);
        check("lw10_const", rd, 32'hDEADBEEF);

        // Byte store and signed/unsigned byte loads.
        run("sb13", 1'b1, 32'h13, 32'h80, 2'b00, 1'b0, 0, rd, er);
        run("lb13", 1'b0, 32'h13, 32'h0, 2'b00, 1'b0, 0, rd, er);
        check("lb13_const", rd, 32'hFFFFFF80);
        run("lbu13", 1'b0, 32'h13, 32'h0, 2'b00, 1'b1, 0, rd, er);
        check("lbu13_const", rd, 32'h00000080);
        run("lw10b", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, rd, er);
        check("lw10b_const", rd, 32'h80ADBEEF);

        // Error cases: misaligned half, out-of-range store leaves word 0 alone.
        run("lh11", 1'b0, 32'h11, 32'h0, 2'b01, 1'b0, 0, rd, er);
        check("lh11_err_const", er, 1);
        exp_rd = ref_load(1'b0, 32'h0, 2'b10, 1'b0);
        run("sw400", 1'b1, 32'h400, 32'h55AA55AA, 2'b10, 1'b0, 0, rd, er);
        check("sw400_err_const", er, 1);
        run("lw0", 1'b0, 32'h0, 32'h0, 2'b10, 1'b0, 0, rd, er);
        check("lw0_unchanged", rd, exp_rd);

        // Response back-pressure for 5 cycles.
        run("stall", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 5, rd, er);

        // Reset while a store waits: aborted, no response, memory unchanged.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678;
        req_size = 2'b10; req_unsigned = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("abort_no_rsp", rsp_valid, 0);
            check("abort_req_ready", req_ready, 1);
        end
        run("lw20", 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 0, rd, er);

        // Randomised traffic, mostly in the initialised window.
        for (int t = 0; t < 60; t++) begin
            we = 1'($urandom);
            sz = 2'($urandom);
            case ($urandom_range(0, 9))
                0:       a = 32'h400 + $urandom_range(0, 255);
                1:       a = $urandom;
                default: a = $urandom_range(0, 63);
            endcase
            run("rand", we, a, $urandom, sz, 1'($urandom), $urandom_range(0, 2), rd, er);
        end

        // LATENCY=0 back-to-back with rsp_ready held high.
        begin
            logic [31:0] b_addr [5];
            logic [1:0]  b_size [5];
            bit          b_we   [5];
            bit          b_uns  [5];
            logic [31:0] b_wd   [5];
            logic [31:0] e_rd;
            bit          e_er;
            b_we   = '{1, 0, 0, 0, 0};
            b_addr = '{32'h8, 32'h8, 32'hA, 32'h9, 32'hB};
            b_size = '{2'b10, 2'b10, 2'b01, 2'b00, 2'b00};
            b_uns  = '{0, 0, 1, 0, 0};
            b_wd   = '{32'hCAFE8F0D, 0, 0, 0, 0};
            for (int i = 0; i < 5; i++) begin
                check("b_req_ready", b_req_ready, 1);
                b_req_valid = 1'b1; b_req_we = b_we[i]; b_req_addr = b_addr[i];
                b_req_size = b_size[i]; b_req_unsigned = b_uns[i]; b_req_wdata = b_wd[i];
                e_er = ref_err(b_addr[i], b_size[i]);
                e_rd = (e_er || b_we[i]) ? 32'h0 : ref_load(1'b1, b_addr[i], b_size[i], b_uns[i]);
                @(posedge clk);
                @(negedge clk);
                check("b_rsp_valid", b_rsp_valid, 1);
                check("b_rsp_rdata", b_rsp_rdata, e_rd);
                check("b_rsp_err", b_rsp_err, e_er);
                check("b_busy", b_req_ready, 0);
                if (b_we[i] && !e_er) ref_store(1'b1, b_addr[i], b_wd[i], b_size[i]);
                @(negedge clk);
            end
            b_req_valid = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit words stored (power of two, 16..4096).
REQ-002 SHALL have parameter LATENCY, default 2, wait cycles inserted before each response (0..7).
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  in  1  request present.
REQ-006 SHALL have port req_ready  out  1  block can accept a request.
REQ-007 SHALL have port req_we  in  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  in  32  byte address.
REQ-009 SHALL have port req_wdata  in  32  store data, right-aligned.
REQ-010 SHALL have port req_size  in  2  00 byte, 01 half, 10 word; 11 is illegal.
REQ-011 SHALL have port req_unsigned  in  1  zero-extend loads when 1, sign-extend when 0.
REQ-012 SHALL have port rsp_valid  out  1  response present.
REQ-013 SHALL have port rsp_ready  in  1  consumer accepts the response.
REQ-014 SHALL have port rsp_rdata  out  32  load data, extended; 0 for stores and errors.
REQ-015 SHALL have port rsp_err  out  1  misaligned, illegal-size or out-of-range access.

Function
REQ-016 SHALL implement an FSM with states IDLE, WAIT and RESP.
REQ-017 SHALL drive req_ready=1 only in IDLE; a request is accepted on a clock edge where req_valid&&req_ready.
REQ-018 SHALL latch we/addr/wdata/size/unsigned on accept, so inputs may change afterwards.
REQ-019 SHALL, on accept, go to WAIT with a countdown loaded to LATENCY-1 when LATENCY>0, or go directly to RESP when LATENCY=0.
REQ-020 SHALL move WAIT->RESP when the countdown is 0, otherwise decrement it.
REQ-021 SHALL assert rsp_valid exactly LATENCY+1 cycles after the accept edge and hold it, with rsp_rdata and rsp_err stable, until rsp_valid&&rsp_ready.
REQ-022 SHALL return to IDLE on the response handshake edge; req_ready=1 in the following cycle; there is no request/response overlap.
REQ-023 SHALL flag an error when: halfword with addr[0]=1; word with addr[1:0]≠0; size=11; or addr[31:2] ≥ DEPTH_WORDS.
REQ-024 SHALL commit a store on the edge entering RESP, and only if no error, using byte enables derived from size and addr[1:0] (byte: lane addr[1:0]; half: lanes addr[1]*2..+1; word: all lanes).
REQ-025 SHALL, for loads, read the word at entry to RESP, extract the lane(s) per size/addr[1:0], then zero- or sign-extend to 32 bits.
REQ-026 SHALL apply a store to the word index addr[31:2]; upper address bits beyond DEPTH_WORDS are an error, never aliased.
REQ-027 SHALL give a load after a completed store to the same address the new data (no stale reads).
REQ-028 SHALL give rsp_err=1 responses rsp_rdata=0 and leave memory unchanged.

Reset
REQ-029 SHALL, on reset, force IDLE, countdown 0, req_ready=1 from the next cycle, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-030 SHALL make reset in WAIT abort the request with no memory write and no response.
REQ-031 SHALL make reset in RESP drop the pending response; a store already committed stays committed.
REQ-032 SHALL NOT clear storage contents on reset.

Structure
REQ-033 SHALL take the size encoding enum and the FSM state enum from shared package dmem_pkg.
REQ-034 SHALL place byte-lane extraction and extension in combinational sub-module dmem_lane_align (inputs: word, addr[1:0], size, unsigned; output: 32-bit data).

Verification
REQ-035 SHALL cover, with LATENCY=2: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rsp_valid 3 cycles after each accept, rdata 0xDEADBEEF, err 0.
REQ-036 SHALL cover: SB 0x13 data 0x80, then LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; LW 0x10 -> 0x80ADBEEF.
REQ-037 SHALL cover: LH 0x11 -> err 1, rdata 0; SW 0x400 with DEPTH_WORDS=256 -> err 1, and a later LW 0x0 is unchanged.
REQ-038 SHALL cover: rsp_ready held 0 for 5 cycles -> rsp_valid/rdata stable, req_ready 0 throughout; handshake -> req_ready 1 the next cycle.
REQ-039 SHALL cover: reset asserted in WAIT of SW 0x20 data 0x12345678 -> no response; LW 0x20 returns the prior value.
REQ-040 SHALL cover: LATENCY=0, back-to-back LW with rsp_ready=1 -> rsp_valid 1 cycle after each accept, one transaction per 2 cycles.
